// File: rtl/alu_addsub_arbiter_if.sv
// Request/response bundle for the AddSub arbiter: two requester channels and one
// tagged response channel. master = requesters/consumer side, slave = arbiter side.
interface alu_addsub_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [4:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  logic [4:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_overflow;
  logic        rsp_zero;
  logic        rsp_err;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero, rsp_err,
    input  rsp_ready
  );
endinterface

// File: rtl/alu_addsub_arbiter.sv
// Round-robin arbiter/sequencer sharing one AddSub unit between two requesters.
// Sequence per op: IDLE (issue operands) -> EXEC (capture AddSub outputs) -> RESP.
module alu_addsub_arbiter #(
  parameter logic [4:0] ADD_OP = 5'd6,
  parameter logic [4:0] SUB_OP = 5'd7
) (
  input  logic                       soc_clk,
  input  logic                       reset,
  alu_addsub_arbiter_if.slave        bus,
  output logic                       busy,
  output logic                       as_dat_ready,
  output logic [31:0]                as_dat1,
  output logic [31:0]                as_dat2,
  output logic [4:0]                 as_instr,
  input  logic [31:0]                as_out,
  input  logic                       as_overflow,
  input  logic                       as_zero
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic        op_id;
  logic        op_err;

  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_result_q;
  logic        rsp_overflow_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;

  logic        grant_valid;
  logic        grant_id;
  logic [4:0]  grant_op;
  logic [31:0] grant_a;
  logic [31:0] grant_b;
  logic        grant_err;

  // On a tie the requester not served last wins; a lone requester always wins.
  always_comb begin
    grant_valid = (state == IDLE) && !reset && (bus.req0_valid || bus.req1_valid);
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = bus.req1_valid;
    end
    grant_op  = grant_id ? bus.req1_op : bus.req0_op;
    grant_a   = grant_id ? bus.req1_a  : bus.req0_a;
    grant_b   = grant_id ? bus.req1_b  : bus.req0_b;
    grant_err = (grant_op != ADD_OP) && (grant_op != SUB_OP);
  end

  assign bus.req0_ready = grant_valid && !grant_id;
  assign bus.req1_ready = grant_valid &&  grant_id;

  assign as_dat_ready = grant_valid;
  assign as_dat1      = grant_valid ? grant_a  : 32'd0;
  assign as_dat2      = grant_valid ? grant_b  : 32'd0;
  assign as_instr     = grant_valid ? grant_op : 5'd0;

  assign busy = (state != IDLE);

  // AddSub registers operands at the grant edge, so its outputs are sampled one
  // edge later in EXEC; id/err are held aside until then so rsp_* change together.
  always_ff @(posedge soc_clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= 1'b1;
      op_id          <= 1'b0;
      op_err         <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= 32'd0;
      rsp_overflow_q <= 1'b0;
      rsp_zero_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            op_id      <= grant_id;
            op_err     <= grant_err;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q   <= as_out;
          rsp_overflow_q <= as_overflow;
          rsp_zero_q     <= as_zero;
          rsp_id_q       <= op_id;
          rsp_err_q      <= op_err;
          rsp_valid_q    <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = rsp_id_q;
  assign bus.rsp_result   = rsp_result_q;
  assign bus.rsp_overflow = rsp_overflow_q;
  assign bus.rsp_zero     = rsp_zero_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_addsub_arbiter.sv
// Scoreboard bench for alu_addsub_arbiter with a behavioural AddSub model
// (one-cycle operand register, carry-out as overflow, illegal op clears operands).
module tb_alu_addsub_arbiter;

  localparam logic [4:0] ADD = 5'd6;
  localparam logic [4:0] SUB = 5'd7;

  logic        soc_clk;
  logic        reset;
  logic        busy;
  logic        as_dat_ready;
  logic [31:0] as_dat1;
  logic [31:0] as_dat2;
  logic [4:0]  as_instr;
  logic [31:0] as_out;
  logic        as_overflow;
  logic        as_zero;

  alu_addsub_arbiter_if ifc ();

  alu_addsub_arbiter #(.ADD_OP(ADD), .SUB_OP(SUB)) dut (
    .soc_clk      (soc_clk),
    .reset        (reset),
    .bus          (ifc),
    .busy         (busy),
    .as_dat_ready (as_dat_ready),
    .as_dat1      (as_dat1),
    .as_dat2      (as_dat2),
    .as_instr     (as_instr),
    .as_out       (as_out),
    .as_overflow  (as_overflow),
    .as_zero      (as_zero)
  );

  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  int cycle = 0;
  always @(posedge soc_clk) cycle <= cycle + 1;

  // AddSub model
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_sub;
  logic [32:0] m_sum;
  always @(posedge soc_clk) begin
    if (as_dat_ready) begin
      if (as_instr == ADD || as_instr == SUB) begin
        m_a   <= as_dat1;
        m_b   <= as_dat2;
        m_sub <= (as_instr == SUB);
      end else begin
        m_a   <= 32'd0;
        m_b   <= 32'd0;
        m_sub <= 1'b0;
      end
    end
  end
  assign m_sum       = m_sub ? ({1'b0, m_a} + {1'b0, ~m_b} + 33'd1) : ({1'b0, m_a} + {1'b0, m_b});
  assign as_out      = m_sum[31:0];
  assign as_overflow = m_sum[32];
  assign as_zero     = (m_sum[31:0] == 32'd0);

  typedef struct {
    logic        id;
    logic [31:0] result;
    logic        ovf;
    logic        zero;
    logic        err;
    int          acc_cycle;
  } exp_t;

  exp_t sb[$];
  int   grant_ids[$];
  int   grant_cycles[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got timeout/unexpected event, expected handshake (cycle %0d)", name, cycle);
  endtask

  // Present one request, wait (bounded) for the grant, check AddSub drive, push expectation.
  task automatic applyStimulus(input logic id, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input logic exp_ovf, input logic exp_zero, input logic exp_err,
                               input bit expect_rsp);
    bit   done;
    logic rdy;
    exp_t e;
    done = 0;
    if (id) begin
      ifc.req1_valid = 1'b1; ifc.req1_op = op; ifc.req1_a = a; ifc.req1_b = b;
    end else begin
      ifc.req0_valid = 1'b1; ifc.req0_op = op; ifc.req0_a = a; ifc.req0_b = b;
    end
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge soc_clk);
      rdy = id ? ifc.req1_ready : ifc.req0_ready;
      if (rdy) begin
        done = 1;
        checkOutput("as_dat_ready", {31'd0, as_dat_ready}, 32'd1);
        checkOutput("as_dat1", as_dat1, a);
        checkOutput("as_dat2", as_dat2, b);
        checkOutput("as_instr", {27'd0, as_instr}, {27'd0, op});
        grant_ids.push_back(int'(id));
        grant_cycles.push_back(cycle);
        if (expect_rsp) begin
          e.id = id; e.result = exp_res; e.ovf = exp_ovf; e.zero = exp_zero; e.err = exp_err;
          e.acc_cycle = cycle;
          sb.push_back(e);
        end
      end
      @(posedge soc_clk);
      #1;
    end
    if (!done) reportFail(id ? "req1_grant_timeout" : "req0_grant_timeout");
    if (id) ifc.req1_valid = 1'b0;
    else    ifc.req0_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    @(negedge soc_clk);
    while ((sb.size() != 0 || busy) && n < 60) begin
      @(negedge soc_clk);
      n++;
    end
    if (n >= 60) reportFail("drain_timeout");
    @(posedge soc_clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every response handshake
  initial begin
    logic prev_valid;
    exp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge soc_clk);
      if (!reset) begin
        if (busy) checkOutput("ready_while_busy", {30'd0, ifc.req1_ready, ifc.req0_ready}, 32'd0);
        if (ifc.rsp_valid && !prev_valid) begin
          if (sb.size() == 0) reportFail("unexpected_response");
          else checkOutput("latency", cycle - sb[0].acc_cycle, 32'd2);
        end
        if (ifc.rsp_valid && ifc.rsp_ready && sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("rsp_id", {31'd0, ifc.rsp_id}, {31'd0, e.id});
          checkOutput("rsp_result", ifc.rsp_result, e.result);
          checkOutput("rsp_overflow", {31'd0, ifc.rsp_overflow}, {31'd0, e.ovf});
          checkOutput("rsp_zero", {31'd0, ifc.rsp_zero}, {31'd0, e.zero});
          checkOutput("rsp_err", {31'd0, ifc.rsp_err}, {31'd0, e.err});
        end
      end
      prev_valid = ifc.rsp_valid;
    end
  end

  initial begin
    reset = 1'b1;
    ifc.rsp_ready  = 1'b0;
    ifc.req0_valid = 1'b1; ifc.req0_op = ADD; ifc.req0_a = 32'd1; ifc.req0_b = 32'd2;
    ifc.req1_valid = 1'b0; ifc.req1_op = 5'd0; ifc.req1_a = 32'd0; ifc.req1_b = 32'd0;

    // Reset state, including a pending request that must not be granted
    repeat (3) @(posedge soc_clk);
    @(negedge soc_clk);
    checkOutput("rst_as_dat_ready", {31'd0, as_dat_ready}, 32'd0);
    checkOutput("rst_req0_ready", {31'd0, ifc.req0_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    checkOutput("rst_rsp_zero", {31'd0, ifc.rsp_zero}, 32'd0);
    checkOutput("rst_rsp_result", ifc.rsp_result, 32'd0);
    @(posedge soc_clk);
    #1;
    reset = 1'b0;
    ifc.req0_valid = 1'b0;
    @(negedge soc_clk);
    checkOutput("idle_as_dat_ready", {31'd0, as_dat_ready}, 32'd0);
    checkOutput("idle_as_dat1", as_dat1, 32'd0);
    checkOutput("idle_as_instr", {27'd0, as_instr}, 32'd0);
    @(posedge soc_clk);
    #1;

    $display("[TB] basic add/sub vectors");
    ifc.rsp_ready = 1'b1;
    applyStimulus(1'b0, ADD, 32'd5, 32'd3, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, SUB, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, SUB, 32'd5, 32'd5, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b0, ADD, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 1'b1);
    waitDrain();
    applyStimulus(1'b1, ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] illegal op");
    applyStimulus(1'b0, 5'd3, 32'd7, 32'd9, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
    waitDrain();
    checkOutput("err_cleared", {31'd0, ifc.rsp_err}, 32'd0);
    checkOutput("zero_held", {31'd0, ifc.rsp_zero}, 32'd1);
    checkOutput("valid_cleared", {31'd0, ifc.rsp_valid}, 32'd0);
    applyStimulus(1'b1, SUB, 32'd10, 32'd3, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] backpressure");
    ifc.rsp_ready = 1'b0;
    applyStimulus(1'b0, ADD, 32'h0000_1234, 32'h0000_1111, 32'h0000_2345, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge soc_clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      @(negedge soc_clk);
      checkOutput("bp_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd1);
      checkOutput("bp_rsp_result", ifc.rsp_result, 32'h0000_2345);
      checkOutput("bp_busy", {31'd0, busy}, 32'd1);
      @(posedge soc_clk);
      #1;
    end
    ifc.rsp_ready = 1'b1;
    @(negedge soc_clk);
    checkOutput("bp_complete_valid", {31'd0, ifc.rsp_valid}, 32'd1);
    @(posedge soc_clk);
    #1;
    @(negedge soc_clk);
    checkOutput("bp_after_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    checkOutput("bp_after_busy", {31'd0, busy}, 32'd0);
    @(posedge soc_clk);
    #1;

    $display("[TB] round-robin with both requesters valid");
    reset = 1'b1;
    @(posedge soc_clk);
    #1;
    reset = 1'b0;
    grant_ids.delete();
    grant_cycles.delete();
    fork
      begin
        applyStimulus(1'b0, ADD, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, ADD, 32'd4, 32'd4, 32'd8, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      begin
        applyStimulus(1'b1, SUB, 32'd9, 32'd4, 32'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, SUB, 32'd2, 32'd2, 32'd0, 1'b1, 1'b1, 1'b0, 1'b1);
      end
    join
    waitDrain();
    checkOutput("rr_grant_count", grant_ids.size(), 32'd4);
    if (grant_ids.size() == 4) begin
      checkOutput("rr_grant0", grant_ids[0], 32'd0);
      checkOutput("rr_grant1", grant_ids[1], 32'd1);
      checkOutput("rr_grant2", grant_ids[2], 32'd0);
      checkOutput("rr_grant3", grant_ids[3], 32'd1);
      for (int i = 1; i < 4; i++) begin
        checkOutput("rr_spacing", grant_cycles[i] - grant_cycles[i-1], 32'd3);
      end
    end

    $display("[TB] reset during EXEC");
    applyStimulus(1'b0, ADD, 32'd11, 32'd22, 32'd33, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge soc_clk);
    checkOutput("rst_exec_as_dat_ready", {31'd0, as_dat_ready}, 32'd0);
    @(posedge soc_clk);
    #1;
    reset = 1'b0;
    @(negedge soc_clk);
    checkOutput("rst_exec_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_exec_rsp_valid", {31'd0, ifc.rsp_valid}, 32'd0);
    @(posedge soc_clk);
    #1;
    grant_ids.delete();
    grant_cycles.delete();
    fork
      applyStimulus(1'b0, SUB, 32'd100, 32'd1, 32'd99, 1'b1, 1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, ADD, 32'd6, 32'd6, 32'd12, 1'b0, 1'b0, 1'b0, 1'b1);
    join
    waitDrain();
    checkOutput("post_rst_grant_count", grant_ids.size(), 32'd2);
    if (grant_ids.size() == 2) checkOutput("post_rst_first_grant", grant_ids[0], 32'd0);
    checkOutput("sb_empty", sb.size(), 32'd0);

    repeat (3) @(posedge soc_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
